pulse_period_meter: RTL and testbench

- Receiving end of the tick-pulse interface: measures the clock cycles between consecutive rising edges of a pulse stream (e.g. a rate-divider tick or a sensor heartbeat).
- Reports each measured period with a one-cycle valid strobe.
- Flags a timeout when the stream stops.
- Used by the alarm controller to confirm that tick sources and sensor heartbeats are alive and at the expected rate.

---
 rtl/pulse_period_meter.sv | 142 ++++++++++++++
 tb/tb_pulse_period_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// ============================================================================
// Module   : pulse_period_meter
// Function : Measures clock cycles between rising edges of a pulse stream,
//            strobes each period and flags a timeout when the stream stops.
//            Optional macro PERIOD_CHECK_EN adds an expected-period compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_period_meter #(
   parameter int WIDTH          = 29,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             meas_en,
   input  logic             pulse_in,
`ifdef PERIOD_CHECK_EN
   input  logic [WIDTH-1:0] expected_period,
   output logic             period_err,
`endif
   output logic [WIDTH-1:0] period_out,
   output logic             period_valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [1:0]       c_IDLE    = 2'd0;
   localparam logic [1:0]       c_ARM     = 2'd1;
   localparam logic [1:0]       c_COUNT   = 2'd2;
   localparam logic [WIDTH-1:0] c_TIMEOUT = WIDTH'(TIMEOUT_CYCLES);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_inc;
   logic [WIDTH-1:0] r_period;
   logic             r_valid;
   logic             r_timeout;
   logic             r_pulse_d;
   logic             w_edge;
   logic             w_cnt_hit;

   // A level already high on entry, or held high, never re-triggers.
   assign w_edge    = pulse_in & ~r_pulse_d;
   assign w_cnt_inc = r_cnt + WIDTH'(1);
   assign w_cnt_hit = (w_cnt_inc == c_TIMEOUT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!meas_en) begin
         w_state_nxt = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:  w_state_nxt = c_ARM;
            c_ARM:   if (w_edge) w_state_nxt = c_COUNT;
            c_COUNT: if (!w_edge && w_cnt_hit) w_state_nxt = c_ARM;
            default: w_state_nxt = c_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (r_state == c_ARM) || (r_state == c_COUNT);
   end

   // Edge beats a coincident timeout so a period of exactly TIMEOUT_CYCLES is reported.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pulse_d <= 1'b0;
         r_cnt     <= '0;
         r_period  <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_pulse_d <= pulse_in;
         r_valid   <= 1'b0;
         if (!meas_en) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end else begin
            case (r_state)
               c_ARM: begin
                  if (w_edge) begin
                     r_cnt     <= '0;
                     r_timeout <= 1'b0;
                  end
               end
               c_COUNT: begin
                  if (w_edge) begin
                     r_period  <= w_cnt_inc;
                     r_valid   <= 1'b1;
                     r_cnt     <= '0;
                     r_timeout <= 1'b0;
                  end else if (w_cnt_hit) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                  end else begin
                     r_cnt     <= w_cnt_inc;
                  end
               end
               default: begin
                  r_cnt <= '0;
               end
            endcase
         end
      end
   end

`ifdef PERIOD_CHECK_EN
   logic r_period_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_period_err <= 1'b0;
      end else if (meas_en && (r_state == c_COUNT)) begin
         if (w_edge) begin
            r_period_err <= (w_cnt_inc != expected_period);
         end else if (w_cnt_hit) begin
            r_period_err <= 1'b1;
         end
      end
   end

   assign period_err = r_period_err;
`endif

   assign period_out   = r_period;
   assign period_valid = r_valid;
   assign timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: directed stimulus, per-cycle model compare.
`default_nettype none

module tb_pulse_period_meter;

   localparam int W  = 29;
   localparam int TO = 16;

   logic         clock = 1'b0;
   logic         reset;
   logic         meas_en;
   logic         pulse_in;
   logic [W-1:0] period_out;
   logic         period_valid;
   logic         timeout;
   logic         busy;
`ifdef PERIOD_CHECK_EN
   logic [W-1:0] expected_period;
   logic         period_err;
`endif

   pulse_period_meter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clock           (clock),
      .reset           (reset),
      .meas_en         (meas_en),
      .pulse_in        (pulse_in),
`ifdef PERIOD_CHECK_EN
      .expected_period (expected_period),
      .period_err      (period_err),
`endif
      .period_out      (period_out),
      .period_valid    (period_valid),
      .timeout         (timeout),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   int           n_pass  = 0;
   int           n_total = 0;
   int           cyc;
   int           m_t0;
   bit           m_active;
   bit           m_ref;
   bit           m_prev;
   bit           m_valid;
   bit           m_timeout;
   bit           m_err;
   logic [W-1:0] m_period;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_ref     = 1'b0;
      m_prev    = 1'b0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
      m_err     = 1'b0;
      m_period  = '0;
   endtask

   // Periods are time differences between edge cycles; a reference edge
   // expires TO cycles after it was seen.
   task automatic model_update(input bit en, input bit p);
      bit e;
      e      = p && !m_prev;
      m_prev = p;
      cyc++;
      m_valid = 1'b0;
      if (!en) begin
         m_active  = 1'b0;
         m_ref     = 1'b0;
         m_timeout = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
      end else if (e) begin
         if (m_ref) begin
            m_period = W'(cyc - m_t0);
            m_valid  = 1'b1;
`ifdef PERIOD_CHECK_EN
            m_err    = (m_period != expected_period);
`endif
         end
         m_t0      = cyc;
         m_ref     = 1'b1;
         m_timeout = 1'b0;
      end else if (m_ref && (cyc - m_t0 == TO)) begin
         m_timeout = 1'b1;
         m_ref     = 1'b0;
`ifdef PERIOD_CHECK_EN
         m_err     = 1'b1;
`endif
      end
   endtask

   task automatic compare();
      chk("period_out",   32'(period_out),   32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_valid));
      chk("timeout",      32'(timeout),      32'(m_timeout));
      chk("busy",         32'(busy),         32'(m_active));
`ifdef PERIOD_CHECK_EN
      chk("period_err",   32'(period_err),   32'(m_err));
`endif
   endtask

   task automatic step(input bit en, input bit p);
      meas_en  = en;
      pulse_in = p;
      @(posedge clock);
      model_update(en, p);
      #1;
      compare();
   endtask

   initial begin
      reset    = 1'b1;
      meas_en  = 1'b0;
      pulse_in = 1'b0;
`ifdef PERIOD_CHECK_EN
      expected_period = W'(5);
`endif
      cyc = 0;
      m_t0 = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_period", 32'(period_out),   0);
      chk("rst_valid",  32'(period_valid), 0);
      chk("rst_timeout",32'(timeout),      0);
      chk("rst_busy",   32'(busy),         0);
      reset = 1'b0;

      // 1-high/4-low stream: period 5 from the second edge on
      step(1, 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 1);
         if (k > 0) begin
            chk("div_valid",   32'(period_valid), 1);
            chk("div_period",  32'(period_out),   5);
            chk("div_timeout", 32'(timeout),      0);
         end
         repeat (4) step(1, 0);
      end

      // asynchronous reset mid-count
      repeat (3) step(1, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_period",  32'(period_out),   0);
      chk("arst_valid",   32'(period_valid), 0);
      chk("arst_timeout", 32'(timeout),      0);
      chk("arst_busy",    32'(busy),         0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("arst_idle", 32'(busy), 0);

      // timeout after silence, recovery, no report for the gap
      step(1, 0);
      step(1, 1);
      repeat (15) step(1, 0);
      chk("to_early", 32'(timeout), 0);
      step(1, 0);
      chk("to_set",   32'(timeout),      1);
      chk("to_noval", 32'(period_valid), 0);
      repeat (3) step(1, 0);
      chk("to_hold",  32'(timeout), 1);
      chk("to_busy",  32'(busy),    1);
      step(1, 1);
      chk("to_clear", 32'(timeout),      0);
      chk("to_nogap", 32'(period_valid), 0);
      repeat (6) step(1, 0);
      step(1, 1);
      chk("rec_valid",  32'(period_valid), 1);
      chk("rec_period", 32'(period_out),   7);

      // edge coincides with the timeout boundary
      repeat (15) step(1, 0);
      step(1, 1);
      chk("bnd_valid",   32'(period_valid), 1);
      chk("bnd_period",  32'(period_out),   16);
      chk("bnd_timeout", 32'(timeout),      0);

      // disable mid-measurement, re-enable with the line already high
      repeat (4) step(1, 0);
      step(1, 1);
      chk("dis_pre", 32'(period_out), 5);
      repeat (3) step(1, 0);
      step(0, 0);
      chk("dis_busy",   32'(busy),         0);
      chk("dis_valid",  32'(period_valid), 0);
      chk("dis_period", 32'(period_out),   5);
      step(0, 1);
      step(1, 1);
      step(1, 1);
      chk("hi_noval",  32'(period_valid), 0);
      chk("hi_period", 32'(period_out),   5);
      step(1, 0);
      step(1, 1);
      chk("first_noval", 32'(period_valid), 0);
      step(1, 0);
      step(1, 0);
      step(1, 1);
      chk("re_valid",  32'(period_valid), 1);
      chk("re_period", 32'(period_out),   3);
      step(1, 0);
      step(1, 1);
      chk("min_valid",  32'(period_valid), 1);
      chk("min_period", 32'(period_out),   2);

      // disable clears an active timeout
      repeat (16) step(1, 0);
      chk("to2_set", 32'(timeout), 1);
      step(0, 0);
      chk("to2_clr",    32'(timeout),    0);
      chk("to2_period", 32'(period_out), 2);

`ifdef PERIOD_CHECK_EN
      step(1, 0);
      step(1, 1);
      repeat (4) step(1, 0);
      step(1, 1);
      chk("chk_p5",   32'(period_out), 5);
      chk("chk_err0", 32'(period_err), 0);
      repeat (5) step(1, 0);
      step(1, 1);
      chk("chk_p6",   32'(period_out), 6);
      chk("chk_err1", 32'(period_err), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
